bram_fifo_ctrl: RTL



---
 rtl/fifo_pkg.sv | 17 +
 rtl/bram_sdp.sv | 35 +++
 rtl/bram_fifo_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and read-mode constants for the block-RAM FIFO.
package fifo_pkg;

   localparam int FIFO_STD  = 0;
   localparam int FIFO_FWFT = 1;

   // Number of words held by a FIFO with a w-bit address.
   function automatic int fifo_depth(input int w);
      return 1 << w;
   endfunction

   // Occupancy counter width: one extra bit so a full FIFO is representable.
   function automatic int fifo_cnt_w(input int w);
      return w + 1;
   endfunction

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// Written in the plain template that synthesis maps onto block RAM.
module bram_sdp
   import fifo_pkg::*;
#(
   parameter int W = 4,
   parameter int B = 8
) (
   input  logic         clk_i,
   input  logic         we_i,
   input  logic [W-1:0] waddr_i,
   input  logic [B-1:0] wdata_i,
   input  logic         re_i,
   input  logic [W-1:0] raddr_i,
   output logic [B-1:0] rdata_o
);

   localparam int DEPTH = fifo_depth(W);

   logic [B-1:0] mem_q [DEPTH];
   logic [B-1:0] rdata_q;

   // Write port.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // Synchronous read port; output holds while re_i is low.
   always_ff @(posedge clk_i) begin
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Block-RAM FIFO controller: pointers, occupancy count, threshold flags,
// overflow/underflow pulses, and an optional first-word-fall-through front end
// (output register plus a one-word skid register covering RAM read latency).
module bram_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int W        = 4,
   parameter int B        = 8,
   parameter int AF_LEVEL = fifo_depth(W) - 2,
   parameter int AE_LEVEL = 2,
   parameter int FWFT     = FIFO_STD
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr,
   input  logic [B-1:0]             wr_data,
   input  logic                     rd,
   output logic [B-1:0]             rd_data,
   output logic                     rd_valid,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [fifo_cnt_w(W)-1:0] count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int DEPTH = fifo_depth(W);
   localparam int CW    = fifo_cnt_w(W);

   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
   localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [W-1:0]  PTR_ONE  = W'(1);

   if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
      $error("bram_fifo_ctrl: thresholds must satisfy AE_LEVEL < AF_LEVEL <= depth");
   end

   logic [W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d, empty_q, empty_d;
   logic          af_q, af_d, ae_q, ae_d;
   logic          ovf_q, ovf_d, unf_q, unf_d;
   logic [B-1:0]  rd_data_q, rd_data_d;
   logic          rd_valid_q, rd_valid_d;
   logic          rd_pipe_q, rd_pipe_d;   // standard mode: RAM read issued last edge
   logic [B-1:0]  skid_q, skid_d;         // FWFT: word fetched while output was busy
   logic          skid_v_q, skid_v_d;
   logic          pend_q, pend_d;         // FWFT: RAM read in flight, data on ram_dout
   logic          wr_acc, rd_acc, ram_re;
   logic [CW-1:0] in_ram;
   logic [B-1:0]  ram_dout;

   assign wr_acc = wr && !full_q;
   assign rd_acc = rd && !empty_q;

   // Words still in RAM that the FWFT front end has not fetched yet.
   assign in_ram = count_q - CW'(rd_valid_q) - CW'(skid_v_q) - CW'(pend_q);

   bram_sdp #(.W(W), .B(B)) u_ram (
      .clk_i   (clk),
      .we_i    (wr_acc),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_data),
      .re_i    (ram_re),
      .raddr_i (rd_ptr_q),
      .rdata_o (ram_dout)
   );

   // Next-state: pointers, count, flags and the mode-specific read path.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      rd_pipe_d  = 1'b0;
      skid_d     = skid_q;
      skid_v_d   = 1'b0;
      pend_d     = 1'b0;
      ram_re     = 1'b0;

      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;

      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      if (FWFT == FIFO_STD) begin
         // RAM read on the accepting edge, output register one edge later.
         ram_re    = rd_acc;
         rd_pipe_d = rd_acc;
         if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (rd_pipe_q) rd_data_d = ram_dout;
         rd_valid_d = rd_pipe_q;
      end else begin
         rd_valid_d = rd_valid_q;
         skid_v_d   = skid_v_q;
         if (rd_acc || !rd_valid_q) begin
            // Output slot free: refill from the oldest staged word.
            if (skid_v_q) begin
               rd_data_d  = skid_q;
               rd_valid_d = 1'b1;
               if (pend_q) skid_d = ram_dout;
               else        skid_v_d = 1'b0;
            end else if (pend_q) begin
               rd_data_d  = ram_dout;
               rd_valid_d = 1'b1;
            end else begin
               rd_valid_d = 1'b0;
            end
         end else if (pend_q) begin
            skid_d   = ram_dout;
            skid_v_d = 1'b1;
         end
         // Fetch only when the arriving word is guaranteed a slot.
         ram_re = (in_ram != '0) && !(rd_valid_d && skid_v_d);
         pend_d = ram_re;
         if (ram_re) rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      empty_d = (FWFT == FIFO_STD) ? (count_d == '0) : !rd_valid_d;
      full_d  = (count_d == CNT_FULL);
      af_d    = (count_d >= CNT_AF);
      ae_d    = (count_d <= CNT_AE);
      ovf_d   = wr && full_q;
      unf_d   = rd && empty_q;
   end

   // State registers; reset discards contents at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         af_q       <= 1'b0;
         ae_q       <= 1'b1;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_pipe_q  <= 1'b0;
         skid_q     <= '0;
         skid_v_q   <= 1'b0;
         pend_q     <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         af_q       <= af_d;
         ae_q       <= ae_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         rd_pipe_q  <= rd_pipe_d;
         skid_q     <= skid_d;
         skid_v_q   <= skid_v_d;
         pend_q     <= pend_d;
      end
   end

   assign rd_data      = rd_data_q;
   assign rd_valid     = rd_valid_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule
